siphash_ctrl: RTL and testbench

Compression/finalization controller for a SipHash-c-d core. It drives one instance of the team's single-SipRound stage (`round`), iterated in a feedback loop.
- Loads key-derived initial state.
- Absorbs pre-formatted 64-bit message words over a valid/ready handshake.
- Runs C_ROUNDS compression rounds per word and D_ROUNDS finalization rounds.
- Emits a 64-bit tag.
- The upstream packer supplies little-endian words; the last word carries (len mod 256) in bits [63:56].

---
 rtl/siphash_pkg.sv | 43 ++++
 rtl/siphash_ctrl_round.sv | 35 +++
 rtl/siphash_ctrl.sv | 126 ++++++++++++
 tb/tb_siphash_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/siphash_pkg.sv
// +--------------------------------------------------------------+
// | siphash_pkg: shared types and constants for the SipHash ctrl |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

package siphash_pkg;

  localparam logic [63:0] IV0       = 64'h736f6d6570736575;
  localparam logic [63:0] IV1       = 64'h646f72616e646f6d;
  localparam logic [63:0] IV2       = 64'h6c7967656e657261;
  localparam logic [63:0] IV3       = 64'h7465646279746573;
  localparam logic [63:0] FINAL_XOR = 64'h00000000000000ff;

  localparam int DEF_C_ROUNDS = 2;
  localparam int DEF_D_ROUNDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ABSORB = 2'd1,
    ST_COMP   = 2'd2,
    ST_FINAL  = 2'd3
  } state_t;

  typedef struct packed {
    logic [63:0] v0;
    logic [63:0] v1;
    logic [63:0] v2;
    logic [63:0] v3;
  } sip_state_t;

  // Round counter must reach the larger of the two round counts.
  function automatic int cnt_width(input int c, input int d);
    return $clog2(((c > d) ? c : d) + 1);
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned n);
    return (x << n) | (x >> (64 - n));
  endfunction

endpackage

`default_nettype wire

// File: rtl/siphash_ctrl_round.sv
// +--------------------------------------------------------------+
// | round: one registered SipRound; output valid a cycle after   |
// | inputs are sampled.  Rev 1.0                                 |
// +--------------------------------------------------------------+
`default_nettype none

module round
  import siphash_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  sip_state_t state_in,
  output sip_state_t state_out
);

  sip_state_t in_q;

  always_ff @(posedge clk) begin
    if (!rst_n) in_q <= '0;
    else        in_q <= state_in;
  end

  always_comb begin
    logic [63:0] a, b, c, d;
    a = in_q.v0; b = in_q.v1; c = in_q.v2; d = in_q.v3;
    a = a + b; b = rotl(b, 13); b = b ^ a; a = rotl(a, 32);
    c = c + d; d = rotl(d, 16); d = d ^ c;
    a = a + d; d = rotl(d, 21); d = d ^ a;
    c = c + b; b = rotl(b, 17); b = b ^ c; c = rotl(c, 32);
    state_out = '{v0: a, v1: b, v2: c, v3: d};
  end

endmodule

`default_nettype wire

// File: rtl/siphash_ctrl.sv
// +--------------------------------------------------------------+
// | siphash_ctrl: SipHash-c-d absorb/compress/finalize control   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module siphash_ctrl
  import siphash_pkg::*;
#(
  parameter int C_ROUNDS = DEF_C_ROUNDS,
  parameter int D_ROUNDS = DEF_D_ROUNDS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [127:0]  key,
  input  logic          start,
  input  logic [63:0]   m_data,
  input  logic          m_last,
  input  logic          m_valid,
  output logic          m_ready,
  output logic [63:0]   hash,
  output logic          hash_valid,
  output logic          busy
);

  localparam int CNT_W = cnt_width(C_ROUNDS, D_ROUNDS);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(C_ROUNDS);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(D_ROUNDS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  sip_state_t       v, rin, ov;
  logic [63:0]      m;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign m_ready = (state == ST_ABSORB);
  assign busy    = (state != ST_IDLE);
  assign accept  = m_valid & m_ready;

  // Round input mux; idles on {v0..v3} so the stage does not toggle needlessly.
  always_comb begin
    rin = v;
    case (state)
      ST_ABSORB: if (accept) rin.v3 = v.v3 ^ m_data;
      ST_COMP: begin
        if (cnt < C_LAST) begin
          rin = ov;
        end else if (last) begin
          rin    = ov;
          rin.v0 = ov.v0 ^ m;
          rin.v2 = ov.v2 ^ FINAL_XOR;
        end
      end
      ST_FINAL: if (cnt < D_LAST) rin = ov;
      default: ;
    endcase
  end

  round u_round (
    .clk       (clk),
    .rst_n     (rst_n),
    .state_in  (rin),
    .state_out (ov)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      v          <= '0;
      m          <= '0;
      last       <= 1'b0;
      cnt        <= '0;
      hash       <= '0;
      hash_valid <= 1'b0;
    end else begin
      hash_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            v.v0  <= key[63:0]   ^ IV0;
            v.v1  <= key[127:64] ^ IV1;
            v.v2  <= key[63:0]   ^ IV2;
            v.v3  <= key[127:64] ^ IV3;
            state <= ST_ABSORB;
          end
        end
        ST_ABSORB: begin
          if (accept) begin
            m     <= m_data;
            last  <= m_last;
            cnt   <= CNT_ONE;
            state <= ST_COMP;
          end
        end
        ST_COMP: begin
          if (cnt < C_LAST) begin
            cnt <= cnt + CNT_ONE;
          end else if (!last) begin
            v.v0  <= ov.v0 ^ m;
            v.v1  <= ov.v1;
            v.v2  <= ov.v2;
            v.v3  <= ov.v3;
            state <= ST_ABSORB;
          end else begin
            cnt   <= CNT_ONE;
            state <= ST_FINAL;
          end
        end
        default: begin
          if (cnt < D_LAST) begin
            cnt <= cnt + CNT_ONE;
          end else begin
            hash       <= ov.v0 ^ ov.v1 ^ ov.v2 ^ ov.v3;
            hash_valid <= 1'b1;
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_siphash_ctrl.sv
// +--------------------------------------------------------------+
// | tb_siphash_ctrl: directed vectors and corner-case sequences  |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
`default_nettype none

module tb_siphash_ctrl;

  logic         clk;
  logic         rst_n;
  logic [127:0] key;
  logic         start;
  logic [63:0]  m_data;
  logic         m_last;
  logic         m_valid;
  logic         m_ready;
  logic [63:0]  hash;
  logic         hash_valid;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int hv_count = 0;

  localparam logic [127:0] KEY     = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [63:0]  H_EMPTY = 64'h726fdb47dd0e0e31;
  localparam logic [63:0]  H_ONE   = 64'h74f839c593dc67fd;
  localparam logic [63:0]  H_EIGHT = 64'h93f5f5799a932462;

  typedef struct {
    logic [127:0] k;
    int           n;
    logic [63:0]  w0;
    logic [63:0]  w1;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs[3];

  siphash_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .start      (start),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .hash       (hash),
    .hash_valid (hash_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (hash_valid === 1'b1) hv_count++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [127:0] k);
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Feeds n words; returns at the sample where hash_valid is first seen.
  task automatic feed(input int n, input logic [63:0] w0, input logic [63:0] w1,
                      input bit chk_busy);
    int waited;
    int k;
    for (int i = 0; i < n; i++) begin
      m_data  = (i == 0) ? w0 : w1;
      m_last  = (i == n - 1);
      m_valid = 1'b1;
      waited  = 0;
      while (!m_ready && waited < 20) begin
        tick();
        waited++;
      end
      if (!m_ready) check("ready_timeout", 64'(m_ready), 64'd1);
      if (i > 0) check("ready_gap", 64'(waited), 64'd2);
      tick();
      m_valid = 1'b0;
    end
    k = 0;
    while (!hash_valid && k < 20) begin
      if (chk_busy) check("busy_during_run", 64'(busy), 64'd1);
      tick();
      k++;
    end
    check("latency", 64'(k), 64'd6);
  endtask

  initial begin
    int hv0;
    int guard;
    bit accepted;
    bit rdy;
    logic [63:0] held;

    rst_n = 1'b0; key = '0; start = 1'b0;
    m_data = '0; m_last = 1'b0; m_valid = 1'b0;
    vecs[0] = '{k: KEY, n: 1, w0: 64'h0, w1: 64'h0, exp: H_EMPTY};
    vecs[1] = '{k: KEY, n: 1, w0: 64'h0100000000000000, w1: 64'h0, exp: H_ONE};
    vecs[2] = '{k: KEY, n: 2, w0: 64'h0706050403020100, w1: 64'h0800000000000000, exp: H_EIGHT};

    tick(); tick();
    rst_n = 1'b1;
    check("rst_hash", hash, 64'h0);
    check("rst_hash_valid", 64'(hash_valid), 64'd0);
    check("rst_m_ready", 64'(m_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    // m_valid while IDLE must not start anything.
    m_valid = 1'b1; tick(); m_valid = 1'b0;
    check("idle_mvalid_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 3; i++) begin
      do_start(vecs[i].k);
      check("start_busy", 64'(busy), 64'd1);
      feed(vecs[i].n, vecs[i].w0, vecs[i].w1, 1'b0);
      check("vec_hash", hash, vecs[i].exp);
      held = hash;
      tick();
      check("vec_pulse_width", 64'(hash_valid), 64'd0);
      check("vec_hash_held", hash, held);
    end

    // Random m_valid stalls with start pulsed while busy.
    hv0 = hv_count;
    do_start(KEY);
    for (int i = 0; i < 2; i++) begin
      m_data = (i == 0) ? vecs[2].w0 : vecs[2].w1;
      m_last = (i == 1);
      accepted = 1'b0;
      guard = 0;
      while (!accepted && guard < 100) begin
        m_valid = 1'($urandom_range(0, 1));
        start   = m_ready ? 1'b0 : 1'($urandom_range(0, 1));
        rdy     = m_ready;
        tick();
        if (rdy && m_valid) accepted = 1'b1;
        guard++;
      end
      m_valid = 1'b0;
      start   = 1'b0;
      if (!accepted) check("rand_accept_timeout", 64'(accepted), 64'd1);
    end
    guard = 0;
    start = 1'b1;
    while (!hash_valid && guard < 20) begin
      tick();
      if (!hash_valid) start = 1'($urandom_range(0, 1));
      guard++;
    end
    start = 1'b0;
    check("rand_latency", 64'(guard), 64'd6);
    check("rand_hash", hash, H_EIGHT);
    tick();
    check("rand_start_ignored", 64'(busy), 64'd0);
    check("rand_single_pulse", 64'(hv_count - hv0), 64'd1);

    // Reset during FINAL aborts without a result.
    hv0 = hv_count;
    do_start(KEY);
    m_data = 64'h0; m_last = 1'b1; m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_hash", hash, 64'h0);
    check("abort_hash_valid", 64'(hash_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_m_ready", 64'(m_ready), 64'd0);
    tick();
    check("abort_no_pulse", 64'(hv_count - hv0), 64'd0);
    do_start(KEY);
    feed(1, 64'h0, 64'h0, 1'b0);
    check("post_reset_hash", hash, H_EMPTY);
    tick();

    // Back-to-back: start in the hash_valid cycle.
    do_start(KEY);
    feed(1, 64'h0, 64'h0, 1'b0);
    check("b2b_first_hash", hash, H_EMPTY);
    key   = KEY;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_pulse_width", 64'(hash_valid), 64'd0);
    feed(1, 64'h0100000000000000, 64'h0, 1'b1);
    check("b2b_second_hash", hash, H_ONE);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
